// File: rtl/dec_gray2bin_chk.sv
// rtl/dec_gray2bin_chk.sv - Gray-to-binary decoding pipeline with Gray step-rule checking
//
// Purpose:
//   Accepts Gray-coded words on a valid/ready handshake.
//   Stage 1 captures each word together with its step-rule flag.
//   Stage 2 holds the decoded binary word and drives the outputs.
//   A saturating counter records delivered words that violated the step rule.
//
// Optional feature:
//   Defining DEC_G2B_STRICT_EN also flags repeated words, i.e. a distance of 0.
//   In the default build, only a distance of two or more bits is flagged.
//
// Parameters:
//   WIDTH - width of the gray and bin words (>= 2)
//   CNT_W - width of err_count
//
// Ports:
//   clk       - clock, rising edge
//   rst       - asynchronous active-high reset
//   in_valid  - gray word offered
//   in_ready  - block can accept a word this cycle
//   gray      - Gray-coded input word
//   out_valid - bin/step_err hold a valid result
//   out_ready - downstream accepts the result
//   bin       - decoded binary word
//   step_err  - this word violated the step rule
//   err_count - saturating count of delivered words with step_err=1

module dec_gray2bin_chk #(
   parameter int WIDTH = 10,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] gray,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] bin,
   output logic             step_err,
   output logic [CNT_W-1:0] err_count
);

   logic             s1_valid_q, s1_valid_d;
   logic [WIDTH-1:0] s1_gray_q, s1_gray_d;
   logic             s1_err_q, s1_err_d;
   logic             s2_valid_q, s2_valid_d;
   logic [WIDTH-1:0] bin_q, bin_d;
   logic             step_err_q, step_err_d;
   logic             prev_valid_q, prev_valid_d;
   logic [WIDTH-1:0] prev_gray_q, prev_gray_d;
   logic [CNT_W-1:0] err_count_q, err_count_d;

   logic             s2_load;
   logic             s1_cap;
   logic [WIDTH-1:0] diff;
   logic             multi_bit;
   logic             zero_bit;
   logic             err_now;
   logic [WIDTH-1:0] dec;

   always_comb begin
      s2_load  = s1_valid_q && (!s2_valid_q || out_ready);
      in_ready = !s1_valid_q || s2_load;
      s1_cap   = in_valid && in_ready;

      // x & (x-1) clears the lowest set bit.
      // A nonzero result therefore means at least two bits differ, so no popcount is needed.
      diff      = gray ^ prev_gray_q;
      multi_bit = (diff & (diff - WIDTH'(1))) != '0;
      zero_bit  = diff == '0;
`ifdef DEC_G2B_STRICT_EN
      err_now   = prev_valid_q && (multi_bit || zero_bit);
`else
      err_now   = prev_valid_q && multi_bit;
`endif

      // Binary bit i is the XOR of all Gray bits from the MSB down to bit i.
      dec = '0;
      dec[WIDTH-1] = s1_gray_q[WIDTH-1];
      for (int i = WIDTH - 2; i >= 0; i--) begin
         dec[i] = dec[i+1] ^ s1_gray_q[i];
      end
   end

   always_comb begin
      s1_valid_d   = s1_valid_q;
      s1_gray_d    = s1_gray_q;
      s1_err_d     = s1_err_q;
      s2_valid_d   = s2_valid_q;
      bin_d        = bin_q;
      step_err_d   = step_err_q;
      prev_valid_d = prev_valid_q;
      prev_gray_d  = prev_gray_q;
      err_count_d  = err_count_q;

      if (s1_cap) begin
         s1_valid_d   = 1'b1;
         s1_gray_d    = gray;
         s1_err_d     = err_now;
         prev_valid_d = 1'b1;
         prev_gray_d  = gray;
      end else if (s2_load) begin
         s1_valid_d = 1'b0;
      end

      if (s2_load) begin
         s2_valid_d = 1'b1;
         bin_d      = dec;
         step_err_d = s1_err_q;
      end else if (s2_valid_q && out_ready) begin
         s2_valid_d = 1'b0;
      end

      if (s2_valid_q && out_ready && step_err_q && (err_count_q != '1)) begin
         err_count_d = err_count_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_valid_q   <= 1'b0;
         s1_gray_q    <= '0;
         s1_err_q     <= 1'b0;
         s2_valid_q   <= 1'b0;
         bin_q        <= '0;
         step_err_q   <= 1'b0;
         prev_valid_q <= 1'b0;
         prev_gray_q  <= '0;
         err_count_q  <= '0;
      end else begin
         s1_valid_q   <= s1_valid_d;
         s1_gray_q    <= s1_gray_d;
         s1_err_q     <= s1_err_d;
         s2_valid_q   <= s2_valid_d;
         bin_q        <= bin_d;
         step_err_q   <= step_err_d;
         prev_valid_q <= prev_valid_d;
         prev_gray_q  <= prev_gray_d;
         err_count_q  <= err_count_d;
      end
   end

   assign out_valid = s2_valid_q;
   assign bin       = bin_q;
   assign step_err  = step_err_q;
   assign err_count = err_count_q;

endmodule

// File: tb/tb_dec_gray2bin_chk.sv
// tb/tb_dec_gray2bin_chk.sv - self-checking bench for dec_gray2bin_chk
module tb_dec_gray2bin_chk;

   localparam int W     = 10;
   localparam int CW    = 3;
   localparam int CMAX  = (1 << CW) - 1;
`ifdef DEC_G2B_STRICT_EN
   localparam bit STRICT = 1'b1;
`else
   localparam bit STRICT = 1'b0;
`endif

   logic          clk;
   logic          rst;
   logic          in_valid;
   logic          in_ready;
   logic [W-1:0]  gray;
   logic          out_valid;
   logic          out_ready;
   logic [W-1:0]  bin;
   logic          step_err;
   logic [CW-1:0] err_count;

   dec_gray2bin_chk #(.WIDTH(W), .CNT_W(CW)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .gray      (gray),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .bin       (bin),
      .step_err  (step_err),
      .err_count (err_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [W-1:0] b;
      logic         e;
   } exp_t;

   typedef struct {
      logic [W-1:0] g;
      logic [W-1:0] b;
      logic         en;
      logic         es;
   } vec_t;

   int n_tests = 0;
   int n_fail  = 0;

   exp_t         exp_q[$];
   logic [W-1:0] m_prev;
   logic         m_pv;
   int           m_cnt;
   int           n_acc;

   logic         s_ready, s_ovalid, s_err;
   logic [W-1:0] s_bin;
   logic [CW-1:0] s_cnt;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      n_tests++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, req);
      end
   endtask

   function automatic logic [W-1:0] g2b(input logic [W-1:0] g);
      logic [W-1:0] b;
      b = '0;
      for (int k = 0; k < W; k++) b = b ^ (g >> k);
      return b;
   endfunction

   task automatic model_reset();
      exp_q.delete();
      m_prev = '0;
      m_pv   = 1'b0;
      m_cnt  = 0;
   endtask

   task automatic cyc(input logic v, input logic [W-1:0] g, input logic ordy);
      exp_t e;
      int   d;
      logic er;
      in_valid  = v;
      gray      = g;
      out_ready = ordy;
      #1;
      s_ready  = in_ready;
      s_ovalid = out_valid;
      s_bin    = bin;
      s_err    = step_err;
      s_cnt    = err_count;
      check("err_count_model", 64'(err_count), 64'(m_cnt));
      if (out_valid && out_ready) begin
         if (exp_q.size() == 0) begin
            check("spurious_delivery", 64'(bin), 64'h0);
            check("spurious_delivery_valid", 64'(out_valid), 64'h0);
         end else begin
            e = exp_q.pop_front();
            check("sb_bin", 64'(bin), 64'(e.b));
            check("sb_step_err", 64'(step_err), 64'(e.e));
            if (e.e && m_cnt < CMAX) m_cnt++;
         end
      end
      if (in_valid && in_ready) begin
         n_acc++;
         d  = $countones(g ^ m_prev);
         er = m_pv && (STRICT ? (d != 1) : (d >= 2));
         m_prev = g;
         m_pv   = 1'b1;
         exp_q.push_back('{g2b(g), er});
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic drain();
      int n;
      n = 0;
      while ((exp_q.size() != 0 || out_valid) && n < 50) begin
         cyc(1'b0, '0, 1'b1);
         n++;
      end
      check("drain_within_budget", 64'(n < 50), 64'h1);
   endtask

   vec_t tbl[14];

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [W-1:0] lg;
      int exp_cnt;
      logic e_sel;

      tbl[0]  = '{10'h000, 10'h000, 1'b0, 1'b0};
      tbl[1]  = '{10'h001, 10'h001, 1'b0, 1'b0};
      tbl[2]  = '{10'h003, 10'h002, 1'b0, 1'b0};
      tbl[3]  = '{10'h002, 10'h003, 1'b0, 1'b0};
      tbl[4]  = '{10'h006, 10'h004, 1'b0, 1'b0};
      tbl[5]  = '{10'h004, 10'h007, 1'b0, 1'b0};
      tbl[6]  = '{10'h000, 10'h000, 1'b0, 1'b0};
      tbl[7]  = '{10'h200, 10'h3FF, 1'b0, 1'b0};
      tbl[8]  = '{10'h000, 10'h000, 1'b0, 1'b0};
      tbl[9]  = '{10'h001, 10'h001, 1'b0, 1'b0};
      tbl[10] = '{10'h006, 10'h004, 1'b1, 1'b1};
      tbl[11] = '{10'h005, 10'h006, 1'b1, 1'b1};
      tbl[12] = '{10'h005, 10'h006, 1'b0, 1'b1};
      tbl[13] = '{10'h3FF, 10'h2AA, 1'b1, 1'b1};

      rst = 1'b1; in_valid = 1'b0; gray = '0; out_ready = 1'b0;
      n_acc = 0;
      model_reset();
      @(negedge clk); @(negedge clk);
      #1;
      check("reset_out_valid", 64'(out_valid), 64'h0);
      check("reset_err_count", 64'(err_count), 64'h0);
      check("reset_bin", 64'(bin), 64'h0);
      check("reset_step_err", 64'(step_err), 64'h0);
      @(negedge clk);
      rst = 1'b0;
      #1;
      check("post_reset_in_ready", 64'(in_ready), 64'h1);
      @(negedge clk);

      // table-driven stream, out_ready held high
      exp_cnt = 0;
      for (int i = 0; i < 16; i++) begin
         if (i < 14) cyc(1'b1, tbl[i].g, 1'b1);
         else        cyc(1'b0, '0, 1'b1);
         check("tbl_in_ready", 64'(s_ready), 64'h1);
         check("tbl_err_count", 64'(s_cnt), 64'(exp_cnt));
         if (i >= 2) begin
            e_sel = STRICT ? tbl[i-2].es : tbl[i-2].en;
            check("tbl_out_valid", 64'(s_ovalid), 64'h1);
            check("tbl_bin", 64'(s_bin), 64'(tbl[i-2].b));
            check("tbl_step_err", 64'(s_err), 64'(e_sel));
            if (e_sel) exp_cnt++;
         end else begin
            check("tbl_latency_idle", 64'(s_ovalid), 64'h0);
         end
      end
      check("tbl_final_count", 64'(err_count), 64'(exp_cnt));
      drain();

      // backpressure
      n_acc = 0;
      cyc(1'b1, 10'h001, 1'b0); check("bp_ready0", 64'(s_ready), 64'h1);
      cyc(1'b1, 10'h003, 1'b0); check("bp_ready1", 64'(s_ready), 64'h1);
      cyc(1'b1, 10'h002, 1'b0); check("bp_ready2", 64'(s_ready), 64'h0);
      check("bp_accepted", 64'(n_acc), 64'h2);
      for (int k = 0; k < 3; k++) begin
         cyc(1'b1, 10'h002, 1'b0);
         check("bp_stall_ready", 64'(s_ready), 64'h0);
         check("bp_stall_valid", 64'(s_ovalid), 64'h1);
         check("bp_stall_bin", 64'(s_bin), 64'h001);
      end
      cyc(1'b1, 10'h002, 1'b1); check("bp_out0", 64'(s_bin), 64'h001);
      cyc(1'b0, '0, 1'b1);      check("bp_out1", 64'(s_bin), 64'h002);
      cyc(1'b0, '0, 1'b1);      check("bp_out2", 64'(s_bin), 64'h003);
      cyc(1'b0, '0, 1'b1);      check("bp_done", 64'(s_ovalid), 64'h0);
      drain();

      // randomized traffic against the model
      lg = '0;
      for (int k = 0; k < 1500; k++) begin
         case ($urandom_range(0, 3))
            0: lg = lg;
            1, 2: lg = lg ^ (W'(1) << $urandom_range(0, W - 1));
            default: lg = W'($urandom);
         endcase
         cyc($urandom_range(0, 3) != 0, lg, $urandom_range(0, 9) < 7);
      end
      drain();

      // saturation: alternate words with every bit flipped
      for (int k = 0; k < 10; k++) cyc(1'b1, (k % 2) ? 10'h3FF : 10'h000, 1'b1);
      drain();
      check("sat_all_ones", 64'(err_count), 64'(CMAX));
      cyc(1'b1, 10'h3FF, 1'b1);
      cyc(1'b1, 10'h000, 1'b1);
      drain();
      check("sat_hold", 64'(err_count), 64'(CMAX));

      // reset with two words in flight
      cyc(1'b1, 10'h001, 1'b0);
      cyc(1'b1, 10'h003, 1'b0);
      in_valid = 1'b0;
      #2;
      rst = 1'b1;
      #1;
      check("midrst_out_valid", 64'(out_valid), 64'h0);
      check("midrst_err_count", 64'(err_count), 64'h0);
      model_reset();
      @(negedge clk); @(negedge clk);
      rst = 1'b0;
      #1;
      check("midrst_in_ready", 64'(in_ready), 64'h1);
      @(negedge clk);
      for (int k = 0; k < 4; k++) begin
         cyc(1'b0, '0, 1'b1);
         check("midrst_no_stale", 64'(s_ovalid), 64'h0);
      end
      cyc(1'b1, 10'h3FF, 1'b1);
      cyc(1'b0, '0, 1'b1);
      cyc(1'b0, '0, 1'b1);
      check("midrst_first_not_flagged", 64'(s_err), 64'h0);
      check("midrst_first_bin", 64'(s_bin), 64'h2AA);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
